// File: rtl/arith_pkg.sv
// Shared arithmetic helpers for the MAC rounding stages.
//   MAC_IN_W / MAC_OUT_W : default accumulator / result widths
//   ROUND_DROP           : number of LSBs removed by rounding at the default widths
//   round_cin()          : round-up decision for half-up or round-half-to-even
package arith_pkg;

  localparam int unsigned MAC_IN_W   = 16;
  localparam int unsigned MAC_OUT_W  = 8;
  localparam int unsigned ROUND_DROP = MAC_IN_W - MAC_OUT_W;

  // Returns 1 when the kept field must be incremented.
  //   rne = 0 : round-half-up, increment on guard alone
  //   rne = 1 : round-half-to-even, a tie (guard set, sticky clear) rounds up only on odd keep
  function automatic logic round_cin(input logic keep_lsb,
                                     input logic guard,
                                     input logic sticky,
                                     input logic rne);
    return guard & (sticky | keep_lsb | ~rne);
  endfunction

endpackage

// File: rtl/n_bit_one_adder.sv
// N-bit incrementer: {cout_o, sum_o} = a_i + cin_i.
// Ports:
//   a_i    [N-1:0]  operand
//   cin_i           carry in (0 or 1 is added)
//   sum_o  [N-1:0]  low N bits of the result
//   cout_o          carry out, set only when a_i is all-ones and cin_i = 1
module n_bit_one_adder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  logic [N:0] full_sum;

  always_comb begin
    full_sum = {1'b0, a_i} + {{N{1'b0}}, cin_i};
  end

  assign sum_o  = full_sum[N-1:0];
  assign cout_o = full_sum[N];

endmodule

// File: rtl/mac_round_stage.sv
// Rounds an unsigned IN_W-bit MAC accumulator value to OUT_W bits, saturating to all-ones when
// the rounding increment overflows. Two-stage valid/ready pipeline, one value per cycle.
// Build option: define MAC_ROUND_RNE_EN for round-half-to-even; default is round-half-up.
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   in_data is valid
//   in_ready   stage accepts in_data this cycle
//   in_data    [IN_W-1:0] accumulator value to round
//   out_valid  out_data/out_sat are valid
//   out_ready  downstream accepts the output
//   out_data   [OUT_W-1:0] rounded (or saturated) result
//   out_sat    rounding overflowed and out_data was forced to all-ones
module mac_round_stage
  import arith_pkg::*;
#(
  parameter int unsigned IN_W  = MAC_IN_W,
  parameter int unsigned OUT_W = MAC_OUT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);

  localparam int unsigned D = IN_W - OUT_W;

  // Guard and sticky each need at least one dropped bit of their own.
  if (IN_W < OUT_W + 2) begin : gen_width_check
    $error("mac_round_stage: IN_W-OUT_W must be at least 2");
  end

`ifdef MAC_ROUND_RNE_EN
  localparam logic RneEn = 1'b1;
`else
  localparam logic RneEn = 1'b0;
`endif

  // Field split of the incoming value
  logic [OUT_W-1:0] keep;
  logic             guard;
  logic             sticky;
  logic             cin;

  always_comb begin
    keep   = in_data[IN_W-1:D];
    guard  = in_data[D-1];
    sticky = |in_data[D-2:0];
    cin    = round_cin(keep[0], guard, sticky, RneEn);
  end

  // Pipeline state
  logic             s1_valid_q, s1_valid_d;
  logic [OUT_W-1:0] s1_a_q, s1_a_d;
  logic             s1_cin_q, s1_cin_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_sat_q, out_sat_d;

  logic             s1_en;
  logic             s2_en;
  logic [OUT_W-1:0] sum;
  logic             cout;

  n_bit_one_adder #(
    .N (OUT_W)
  ) u_adder (
    .a_i    (s1_a_q),
    .cin_i  (s1_cin_q),
    .sum_o  (sum),
    .cout_o (cout)
  );

  // Ready propagates combinationally back through both stages so a full pipe
  // with a draining output still accepts a new value every cycle.
  always_comb begin
    s2_en = ~out_valid_q | out_ready;
    s1_en = ~s1_valid_q | s2_en;
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_cin_d    = s1_cin_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    if (s1_en) begin
      // S1 empties when it advances without a new value arriving.
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d   = keep;
        s1_cin_d = cin;
      end
    end

    if (s2_en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = cout ? {OUT_W{1'b1}} : sum;
        out_sat_d  = cout;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_cin_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_cin_q    <= s1_cin_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready  = s1_en;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_mac_round_stage.sv
// Scoreboard bench for mac_round_stage (IN_W=16, OUT_W=8). Expected values are hand-computed
// per vector; the RNE build selects its own expectations when MAC_ROUND_RNE_EN is defined.
module tb_mac_round_stage;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [15:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sat;

  mac_round_stage #(
    .IN_W  (16),
    .OUT_W (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MAC_ROUND_RNE_EN
  localparam bit Rne = 1'b1;
`else
  localparam bit Rne = 1'b0;
`endif

  typedef struct {
    logic [7:0]  data;
    logic        sat;
    bit          lat_chk;
    int          acc_cyc;
    logic [15:0] src;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accepts = 0;
  bit lat_chk = 1'b1;
  bit push_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a transfer happens at the next rising edge when valid & ready at the falling edge.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data=%h sat=%b, required no output", out_data,
                 out_sat);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (out_data !== e.data || out_sat !== e.sat) begin
          errors++;
          $display("FAIL out_%h: got data=%h sat=%b, required data=%h sat=%b", e.src, out_data,
                   out_sat, e.data, e.sat);
        end
        if (e.lat_chk) begin
          checks++;
          if (cyc != e.acc_cyc + 2) begin
            errors++;
            $display("FAIL latency_%h: got %0d cycles, required 2", e.src, cyc - e.acc_cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Caller is positioned just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [15:0] d, input logic [7:0] ed, input logic es);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        if (push_en) exp_q.push_back('{data: ed, sat: es, lat_chk: lat_chk, acc_cyc: cyc,
                                        src: d});
        accepts++;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout_%h: got in_ready=0 for 50 cycles, required acceptance", d);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  logic [7:0] held;
  bit         have_held;
  int         acc0;

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #3;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_data", {24'b0, out_data}, 32'd0);
    check("reset_out_sat", {31'b0, out_sat}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Rounding vectors, spaced out
    send(16'h1280, Rne ? 8'h12 : 8'h13, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    send(16'h1380, 8'h14, 1'b0);
    send(16'h12C0, 8'h13, 1'b0);
    send(16'h127F, 8'h12, 1'b0);
    send(16'hFF80, 8'hFF, 1'b1);
    send(16'hFF7F, 8'hFF, 1'b0);
    repeat (4) @(posedge clk);
    #1;

    // Back-to-back stream
    send(16'h0100, 8'h01, 1'b0);
    send(16'h0280, Rne ? 8'h02 : 8'h03, 1'b0);
    send(16'h0380, 8'h04, 1'b0);
    send(16'h0481, 8'h05, 1'b0);
    send(16'h0000, 8'h00, 1'b0);
    send(16'hFE80, Rne ? 8'hFE : 8'hFF, 1'b0);
    send(16'hFFFF, 8'hFF, 1'b1);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: output stalled for 4 cycles while input keeps offering
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    acc0      = accepts;
    have_held = 1'b0;
    fork
      begin
        send(16'h2080, Rne ? 8'h20 : 8'h21, 1'b0);
        send(16'h3000, 8'h30, 1'b0);
        send(16'h40C0, 8'h41, 1'b0);
        send(16'h5180, 8'h52, 1'b0);
      end
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          #1;
          if (out_valid) begin
            if (have_held) check("stall_hold_data", {24'b0, out_data}, {24'b0, held});
            else begin
              held      = out_data;
              have_held = 1'b1;
            end
          end
        end
        check("stall_accepts", accepts - acc0, 32'd2);
        check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        check("stall_out_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 32'd0);

    // Reset with both stages full
    out_ready = 1'b0;
    push_en   = 1'b0;
    send(16'h6000, 8'h60, 1'b0);
    send(16'h7000, 8'h70, 1'b0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_out_data", {24'b0, out_data}, 32'd0);
    check("async_rst_out_sat", {31'b0, out_sat}, 32'd0);
    check("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    push_en   = 1'b1;
    lat_chk   = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    send(16'h1280, Rne ? 8'h12 : 8'h13, 1'b0);

    // Final drain
    for (int i = 0; i < 20 && (exp_q.size() != 0 || out_valid); i++) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 32'd0);
    check("final_out_valid", {31'b0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
